// File: rtl/fifo_pkg.sv
// Shared defaults and sizing helper for the synchronous FIFO slice.
package fifo_pkg;
  localparam int DATA_W_DEF = 128;
  localparam int DEPTH_DEF  = 1024;
  localparam int UPP_TH_DEF = 4;
  localparam int LOW_TH_DEF = 2;

  // Occupancy must represent 0..DEPTH inclusive, hence one bit above the pointer width.
  function automatic int cnt_width(input int depth);
    return $clog2(depth) + 1;
  endfunction
endpackage

// File: rtl/fifo_mem.sv
// Simple dual-port RAM: one write port, one registered read port with a
// resettable output register (the array itself is never cleared).
module fifo_mem #(
  parameter int  DATA_W = 8,
  parameter int  DEPTH  = 16,
  localparam int AW     = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_i,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic              re_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  always_ff @(posedge clk) begin
    if (we_i) mem_q[waddr_i] <= wdata_i;
  end

  // Read-before-write on an address collision returns the old word.
  always_ff @(posedge clk) begin
    if (rst_i)     rdata_q <= '0;
    else if (re_i) rdata_q <= mem_q[raddr_i];
  end

  assign rdata_o = rdata_q;
endmodule

// File: rtl/sync_fifo.sv
// Single-clock FIFO: pointers, occupancy, registered status flags and
// overflow/underflow pulses around an inferred dual-port RAM.
module sync_fifo
  import fifo_pkg::*;
#(
  parameter int  DATA_W = DATA_W_DEF,
  parameter int  DEPTH  = DEPTH_DEF,
  parameter int  UPP_TH = UPP_TH_DEF,
  parameter int  LOW_TH = LOW_TH_DEF,
  localparam int CNT_W  = cnt_width(DEPTH)
) (
  input  logic              clk,
  input  logic              rstn,
  input  logic              i_wren,
  input  logic [DATA_W-1:0] i_wrdata,
  input  logic              i_rden,
  output logic [DATA_W-1:0] o_rddata,
  output logic              o_full,
  output logic              o_empty,
  output logic              o_alm_full,
  output logic              o_alm_empty,
  output logic [CNT_W-1:0]  o_count,
  output logic              o_overflow,
  output logic              o_underflow
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW-1:0]    PTR_ONE = AW'(1);
  localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
  localparam logic [CNT_W-1:0] FULL_C  = CNT_W'(DEPTH);
  localparam logic [CNT_W-1:0] AF_C    = CNT_W'(DEPTH - UPP_TH);
  localparam logic [CNT_W-1:0] AE_C    = CNT_W'(LOW_TH);

  logic [AW-1:0]    wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             full_q, empty_q, af_q, ae_q, ovf_q, unf_q;
  logic             wr_acc, rd_acc;

  always_comb begin
    rd_acc   = i_rden & ~empty_q;
    wr_acc   = i_wren & (~full_q | rd_acc);
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (wr_acc) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (rd_acc) rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({wr_acc, rd_acc})
      2'b10:   cnt_d = cnt_q + CNT_ONE;
      2'b01:   cnt_d = cnt_q - CNT_ONE;
      default: cnt_d = cnt_q;
    endcase
  end

  // rstn is active-high despite its name; flags follow cnt_d so they agree with o_count.
  always_ff @(posedge clk) begin
    if (rstn) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
      af_q     <= 1'b0;
      ae_q     <= 1'b1;
      ovf_q    <= 1'b0;
      unf_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      full_q   <= (cnt_d == FULL_C);
      empty_q  <= (cnt_d == '0);
      af_q     <= (cnt_d >= AF_C);
      ae_q     <= (cnt_d <= AE_C);
      ovf_q    <= i_wren & full_q & ~rd_acc;
      unf_q    <= i_rden & empty_q;
    end
  end

  fifo_mem #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH)
  ) u_mem (
    .clk     (clk),
    .rst_i   (rstn),
    .we_i    (wr_acc & ~rstn),
    .waddr_i (wr_ptr_q),
    .wdata_i (i_wrdata),
    .re_i    (rd_acc),
    .raddr_i (rd_ptr_q),
    .rdata_o (o_rddata)
  );

  assign o_full      = full_q;
  assign o_empty     = empty_q;
  assign o_alm_full  = af_q;
  assign o_alm_empty = ae_q;
  assign o_count     = cnt_q;
  assign o_overflow  = ovf_q;
  assign o_underflow = unf_q;
endmodule
